dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (dmem) between two requesters: the processor (P) and the debug/loader port (D).
- Arbitrates every cycle with bounded-burst round-robin, drives the dmem address/data/wren pins and returns read data to the owner after the fixed RAM read latency.
- Sits between the processor's dmem pins and the dmem instance in the top level, clocked by the dmem clock.
- Keeps a saturating conflict counter for debug visibility.

Parameters:
- ADDR_W, 12, dmem address width.
- DATA_W, 32, data word width.
- READ_LAT, 1, dmem read latency in cycles (legal 1..4).
- BURST_MAX, 4, maximum consecutive grants to one requester while the other waits (legal 1..255).
- CNT_W, 16, width of the conflict counter.

Ports:
- clock  in  1  dmem-domain clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- p_req  in  1  processor access request; must hold p_we/p_addr/p_wdata stable until p_gnt.
- p_we  in  1  1 = write, 0 = read.
- p_addr  in  ADDR_W  word address.
- p_wdata  in  DATA_W  write data.
- p_gnt  out  1  request accepted this cycle (combinational).
- p_rvalid  out  1  read data valid.
- p_rdata  out  DATA_W  read data.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the p_ group, for the debug/loader port.
- mem_address  out  ADDR_W  to dmem address.
- mem_data  out  DATA_W  to dmem data.
- mem_wren  out  1  to dmem wren.
- mem_q  in  DATA_W  from dmem q.
- conflict_cnt  out  CNT_W  cycles in which both requested; saturates at all-ones.

Behaviour:
- State:
  - owner (P/D), reset P.
  - run_cnt, 8 bits, reset 0.
  - rd_pipe, READ_LAT entries of {valid, who}, reset all invalid.
  - conflict_cnt, reset 0.
- Grant decision, combinational from req inputs and state:
  - Neither requesting: no grant.
  - Only one requesting: grant it.
  - Both requesting: grant owner if run_cnt < BURST_MAX, else grant the other.
- At most one of p_gnt/d_gnt is high in any cycle. Neither grant is asserted while reset is low.
- Memory drive:
  - Granted cycle: mem_address/mem_data/mem_wren = granted requester's addr/wdata/we.
  - Idle cycle: mem_address = 0, mem_data = 0, mem_wren = 0.
- On a clock edge with a grant to X:
  - X == owner: run_cnt <= min(run_cnt+1, BURST_MAX).
  - Otherwise: owner <= X, run_cnt <= 1.
  - No grant: owner and run_cnt hold.
- Read return:
  - A granted read (we = 0) at cycle t enters rd_pipe.
  - x_rvalid = 1 in cycle t+READ_LAT, with x_rdata = mem_q.
  - Outside that cycle x_rdata = 0 and x_rvalid = 0.
  - Writes produce no rvalid.
  - Back-to-back reads are fully pipelined: one grant per cycle, one rvalid per cycle.
- conflict_cnt increments on every edge where p_req and d_req are both 1 (granted or not). It holds at 2^CNT_W-1.
- Write followed by a read of the same address in the next cycle returns the new data; the arbiter adds no forwarding.
- Reset low mid-operation:
  - All state returns to reset values on that edge.
  - Outstanding reads are discarded: no rvalid appears for any read granted before reset.
  - Outputs are at reset values (gnt/rvalid/rdata/mem_* = 0) during every cycle reset is low.
- The starvation bound: a continuously requesting loser is granted within BURST_MAX cycles.

Decomposition:
- Shared package: the requester-id encoding (REQ_P = 0, REQ_D = 1) and the reset values of owner/run_cnt, so the debug loader and top level use the same ids.
- One natural sub-module, rd_return_pipe: a READ_LAT-deep {valid, who} shift register with synchronous active-low clear, reused for imem debug reads.
- Arbitration FSM and counters stay in dmem_arbiter.

Test Plan:
1. Reset low 3 cycles, then high with no requests → all outputs 0, conflict_cnt = 0, no gnt.
2. P only: write addr 0x010 data 0xDEADBEEF, next cycle read 0x010 → p_gnt each cycle, mem_wren = 1 then 0, p_rvalid one cycle later with p_rdata = 0xDEADBEEF, d_* stay 0.
3. Both requesting reads for 12 cycles, BURST_MAX = 4 → grant pattern P,P,P,P,D,D,D,D,P,P,P,P, and conflict_cnt = 12.
4. READ_LAT = 2: D reads 0x001, 0x002, 0x003 back-to-back (preloaded 0x11, 0x22, 0x33) → d_rvalid in cycles t+2..t+4 with data 0x11, 0x22, 0x33 in order.
5. P read granted, reset pulled low the following cycle → no p_rvalid ever appears, owner = P and run_cnt = 0 after release.
6. CNT_W = 4, both requesting for 20 cycles → conflict_cnt reaches 0xF and stays at 0xF.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the debug loader:
// requester ids, arbitration reset values and the read-return pipe entry.
package dmem_arbiter_pkg;

    typedef enum logic {
        REQ_P = 1'b0,  // processor
        REQ_D = 1'b1   // debug / loader port
    } req_id_t;

    localparam req_id_t    OWNER_RST   = REQ_P;
    localparam logic [7:0] RUN_CNT_RST = 8'd0;

    // One in-flight read: whether it is live and whom its data belongs to.
    typedef struct packed {
        logic    valid;
        req_id_t who;
    } rd_entry_t;

endpackage

// File: rtl/rd_return_pipe.sv
// Fixed-depth {valid, who} delay line that tags memory read data with its
// owner. Shared between the dmem arbiter and imem debug reads.
module rd_return_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic reset,     // synchronous, active-low clear
    input  logic in_valid,
    input  logic in_who,
    output logic out_valid,
    output logic out_who
);

    rd_entry_t [DEPTH-1:0] stage_q;

    // Shift a new entry in every cycle; a cleared pipe drops all in-flight reads.
    always_ff @(posedge clock) begin
        // NOTE: this is a control pipeline, not a data memory, so every stage
        // is cleared; an uncleared valid bit would emit a stale rvalid.
        if (!reset) begin
            stage_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of its predecessor, which is what makes this a shift.
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_q[i] <= stage_q[i-1];
            end
            stage_q[0] <= '{valid: in_valid, who: req_id_t'(in_who)};
        end
    end

    assign out_valid = stage_q[DEPTH-1].valid;
    assign out_who   = stage_q[DEPTH-1].who;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous dmem between the processor (P) and the
// debug/loader port (D) using bounded-burst round-robin, routes read data
// back to its owner after the RAM latency, and counts contended cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 1,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [7:0] BURST_LIM = BURST_MAX[7:0];

    req_id_t          owner_q, owner_d;
    logic [7:0]       run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] conflict_q;
    logic             gnt_any;
    req_id_t          gnt_who;
    logic             pipe_valid;
    logic             pipe_who;

    // Grant decision: sole requester wins; under contention the owner keeps
    // the port until it has used up its burst allowance.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        gnt_any = 1'b0;
        gnt_who = owner_q;
        if (reset) begin
            if (p_req && d_req) begin
                gnt_any = 1'b1;
                if (run_cnt_q < BURST_LIM) begin
                    gnt_who = owner_q;
                end else begin
                    gnt_who = (owner_q == REQ_P) ? REQ_D : REQ_P;
                end
            end else if (p_req) begin
                gnt_any = 1'b1;
                gnt_who = REQ_P;
            end else if (d_req) begin
                gnt_any = 1'b1;
                gnt_who = REQ_D;
            end
        end
    end

    assign p_gnt = gnt_any && (gnt_who == REQ_P);
    assign d_gnt = gnt_any && (gnt_who == REQ_D);

    // Drive the RAM pins from the granted requester, zero when idle.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (p_gnt) begin
            mem_address = p_addr;
            mem_data    = p_wdata;
            mem_wren    = p_we;
        end else if (d_gnt) begin
            mem_address = d_addr;
            mem_data    = d_wdata;
            mem_wren    = d_we;
        end
    end

    // Ownership / burst-length next state.
    always_comb begin
        owner_d   = owner_q;
        run_cnt_d = run_cnt_q;
        if (gnt_any) begin
            if (gnt_who == owner_q) begin
                run_cnt_d = (run_cnt_q < BURST_LIM) ? run_cnt_q + 8'd1 : BURST_LIM;
            end else begin
                owner_d   = gnt_who;
                run_cnt_d = 8'd1;
            end
        end
    end

    // Ownership / burst-length state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_q   <= OWNER_RST;
            run_cnt_q <= RUN_CNT_RST;
        end else begin
            owner_q   <= owner_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    // Saturating count of cycles in which both sides wanted the RAM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            conflict_q <= '0;
        end else if (p_req && d_req && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_q <= conflict_q + 1'b1;
        end
    end

    assign conflict_cnt = reset ? conflict_q : '0;

    rd_return_pipe #(
        .DEPTH (READ_LAT)
    ) u_rd_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (gnt_any && !mem_wren),
        .in_who    (gnt_who),
        .out_valid (pipe_valid),
        .out_who   (pipe_who)
    );

    // Returned data goes only to the tagged owner; outputs are quiet in reset.
    assign p_rvalid = reset && pipe_valid && (pipe_who == REQ_P);
    assign d_rvalid = reset && pipe_valid && (pipe_who == REQ_D);
    assign p_rdata  = p_rvalid ? mem_q : '0;
    assign d_rdata  = d_rvalid ? mem_q : '0;

endmodule
